time_set_ctrl: RTL



---
 rtl/time_pkg.sv | 38 +++
 rtl/btn_event.sv | 69 ++++++
 rtl/time_set_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared types and constants for the time-set controller.
// Holds the FSM state enum, edit-field codes, widths and wrap helper.
package time_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_HR  = 5'd23;

  typedef enum logic [2:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S,
    COMMIT
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_H    = 2'd1;
  localparam logic [1:0] FLD_M    = 2'd2;
  localparam logic [1:0] FLD_S    = 2'd3;

  // One wrapping step within 0..max; out-of-range inputs land in range.
  function automatic logic [5:0] wrap_step(
    input logic [5:0] v,
    input logic [5:0] max,
    input logic       up
  );
    if (up)
      return (v >= max) ? 6'd0 : v + 6'd1;
    else
      return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/btn_event.sv
// Button rising-edge detector with hold-to-auto-repeat.
// Ports: clk, reset_n, i_btn, i_other (opposing button), i_clr, o_step.
module btn_event #(
  parameter int HOLD_CYC = 50000000,
  parameter int RPT_CYC  = 10000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  input  logic i_other,
  input  logic i_clr,
  output logic o_step
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(RPT_CYC + 1);

  logic          r_arm;
  logic          r_prev;
  logic          r_rep_on;
  logic [HW-1:0] r_hold;
  logic [RW-1:0] r_rpt;

  logic w_edge;
  logic w_hold_ok;
  logic w_hold_hit;
  logic w_rpt_hit;

  // r_arm keeps a button held across reset release from firing.
  assign w_edge     = i_btn & ~r_prev & r_arm;
  assign w_hold_ok  = i_btn & ~i_other & ~i_clr;
  assign w_hold_hit = (r_hold == HW'(HOLD_CYC - 1));
  assign w_rpt_hit  = (r_rpt == RW'(RPT_CYC - 1));

  assign o_step = w_edge
                | (w_hold_ok & (r_rep_on ? w_rpt_hit : w_hold_hit));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_arm  <= 1'b1;
      r_prev <= i_btn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold   <= '0;
      r_rpt    <= '0;
      r_rep_on <= 1'b0;
    end else if (!w_hold_ok) begin
      r_hold   <= '0;
      r_rpt    <= '0;
      r_rep_on <= 1'b0;
    end else if (!r_rep_on) begin
      if (w_hold_hit) begin
        r_rep_on <= 1'b1;
        r_rpt    <= '0;
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end else begin
      r_rpt <= w_rpt_hit ? '0 : r_rpt + RW'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// 1 Hz tick generator and button-driven set-time FSM for the clock counter.
// In: clk, reset_n, btn_*, cur_*; out: tick_1hz, load, set_*, set_active, edit_field, blink.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int BLINK_CYC = 25000000,
  parameter int HOLD_CYC  = 50000000,
  parameter int RPT_CYC   = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_cancel,
  input  logic [SEC_W-1:0] cur_s,
  input  logic [MIN_W-1:0] cur_m,
  input  logic [HR_W-1:0]  cur_h,
  output logic             tick_1hz,
  output logic             load,
  output logic [SEC_W-1:0] set_s,
  output logic [MIN_W-1:0] set_m,
  output logic [HR_W-1:0]  set_h,
  output logic             set_active,
  output logic [1:0]       edit_field,
  output logic             blink
);

  localparam int DW = $clog2(CLK_HZ);
  localparam int BW = $clog2(BLINK_CYC + 1);

  state_t r_state;
  state_t w_next;

  logic          r_arm;
  logic          r_mprev;
  logic          r_cprev;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bcnt;
  logic          r_blink;

  logic [SEC_W-1:0] r_s;
  logic [MIN_W-1:0] r_m;
  logic [HR_W-1:0]  r_h;

  logic w_mode_ev;
  logic w_cncl_ev;
  logic w_in_set;
  logic w_clr;
  logic w_inc_step;
  logic w_dec_step;
  logic w_edit;

  assign w_mode_ev = btn_mode & ~r_mprev & r_arm;
  assign w_cncl_ev = btn_cancel & ~r_cprev & r_arm;
  assign w_in_set  = (r_state == SET_H)
                   | (r_state == SET_M)
                   | (r_state == SET_S);
  assign w_clr     = ~w_in_set | w_mode_ev | w_cncl_ev;
  // Simultaneous inc and dec cancel out.
  assign w_edit    = w_in_set & ~w_mode_ev & ~w_cncl_ev
                   & (w_inc_step ^ w_dec_step);

  btn_event #(
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) u_inc (
    .clk    (clk),
    .reset_n(reset_n),
    .i_btn  (btn_inc),
    .i_other(btn_dec),
    .i_clr  (w_clr),
    .o_step (w_inc_step)
  );

  btn_event #(
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) u_dec (
    .clk    (clk),
    .reset_n(reset_n),
    .i_btn  (btn_dec),
    .i_other(btn_inc),
    .i_clr  (w_clr),
    .o_step (w_dec_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_arm   <= 1'b0;
      r_mprev <= 1'b0;
      r_cprev <= 1'b0;
    end else begin
      r_state <= w_next;
      r_arm   <= 1'b1;
      r_mprev <= btn_mode;
      r_cprev <= btn_cancel;
    end
  end

  always_comb begin
    w_next     = r_state;
    tick_1hz   = 1'b0;
    load       = 1'b0;
    set_active = 1'b0;
    edit_field = FLD_NONE;
    unique case (r_state)
      RUN: begin
        tick_1hz = (r_div == DW'(CLK_HZ - 1));
        if (w_mode_ev) w_next = SET_H;
      end
      SET_H: begin
        set_active = 1'b1;
        edit_field = FLD_H;
        if (w_cncl_ev)      w_next = RUN;
        else if (w_mode_ev) w_next = SET_M;
      end
      SET_M: begin
        set_active = 1'b1;
        edit_field = FLD_M;
        if (w_cncl_ev)      w_next = RUN;
        else if (w_mode_ev) w_next = SET_S;
      end
      SET_S: begin
        set_active = 1'b1;
        edit_field = FLD_S;
        if (w_cncl_ev)      w_next = RUN;
        else if (w_mode_ev) w_next = COMMIT;
      end
      COMMIT: begin
        load   = 1'b1;
        w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end

  // Divider only runs while staying in RUN, so any re-entry starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_div <= '0;
    else if (r_state == RUN && w_next == RUN)
      r_div <= tick_1hz ? '0 : r_div + DW'(1);
    else
      r_div <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_m <= '0;
      r_s <= '0;
    end else if (r_state == RUN && w_mode_ev) begin
      r_h <= (cur_h > MAX_HR)  ? '0 : cur_h;
      r_m <= (cur_m > MAX_MIN) ? '0 : cur_m;
      r_s <= (cur_s > MAX_SEC) ? '0 : cur_s;
    end else if (w_edit) begin
      unique case (r_state)
        SET_H:
          r_h <= HR_W'(wrap_step({1'b0, r_h}, {1'b0, MAX_HR}, w_inc_step));
        SET_M:
          r_m <= wrap_step(r_m, MAX_MIN, w_inc_step);
        SET_S:
          r_s <= wrap_step(r_s, MAX_SEC, w_inc_step);
        default: ;
      endcase
    end
  end

  // An edit restarts the phase with the digit visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (!w_in_set || w_edit) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_bcnt == BW'(BLINK_CYC - 1)) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt <= r_bcnt + BW'(1);
    end
  end

  assign blink = r_blink & set_active;
  assign set_h = r_h;
  assign set_m = r_m;
  assign set_s = r_s;

endmodule
